int_issue_queue: RTL and testbench
==================================

# int_issue_queue

Integer issue queue that sits directly downstream of dispatch and consumes its compacted `uop_to_int` bundle. It buffers up to `IQ_SIZE` micro-ops and tracks source-operand readiness from writeback wakeup tags. Each cycle it issues up to `ISSUE_WIDTH` ready micro-ops to the integer execution ports, lowest slot index first. Accept is all-or-nothing per dispatch group, with backpressure via `ready_out`.

## Interface
- `IQ_SIZE`, 16, number of entries; must be ≥ `DISPATCH_WIDTH`.
- `ISSUE_WIDTH`, 2, integer execution ports.
- `WB_WIDTH`, 4, wakeup broadcast ports.
- `PRF_IDX_W`, 6, physical register tag width.
- `DISPATCH_WIDTH` is the global macro (4).
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  pipeline flush; synchronous clear of all entries.
- `uop_in`  in  `micro_op_t [DISPATCH_WIDTH]`  compacted from dispatch; slot k valid implies all slots below k are valid.
- `ready_out`  out  1  queue can accept a full group this cycle.
- `wb_valid`  in  `[WB_WIDTH]`  wakeup broadcast valid.
- `wb_prd`  in  `[WB_WIDTH][PRF_IDX_W]`  destination tag being written back.
- `ex_busy`  in  `[ISSUE_WIDTH]`  execution port cannot accept a micro-op this cycle.
- `uop_out`  out  `micro_op_t [ISSUE_WIDTH]`  issued micro-ops; `.valid` marks occupied ports.

## Operation
- Entry state: `valid`, full `micro_op_t`, `rs1_rdy`, `rs2_rdy`.
- `micro_op_t` fields used: `valid`, `prs1`, `prs2`, `prs1_ready`, `prs2_ready`.
- **Enqueue.** Occurs when `ready_out && !flush`.
  - Valid `uop_in[k]` are written to the k-th lowest free slot.
  - Ready bits initialise as `prs*_ready` OR a same-cycle match against any valid `wb_prd`.
- **`ready_out`.** Equals (free entries ≥ `DISPATCH_WIDTH`), computed from registered state only.
  - Entries issuing this cycle are not counted as free, so there is no combinational path from `ex_busy`.
  - When `ready_out` is low, dispatch holds `uop_in` stable; the group is dropped by this block.
- **Wakeup.** For every valid entry, `wb_valid[w] && wb_prd[w]==prs1` sets `rs1_rdy` at the edge; likewise for rs2.
  - Tag 0 broadcasts are ignored; rename marks x0 sources ready.
- **Select.**
  - Eligible entry: `valid && rs1_rdy && rs2_rdy`.
  - Port p takes the lowest-index eligible entry not claimed by ports < p.
  - A port with `ex_busy[p]` is skipped; its `uop_out[p]` is all-zero, and its candidate stays available to later ports.
  - Issued entries are cleared at the edge.
- **Flush.** `uop_out` is forced all-zero in the flush cycle; enqueue is suppressed; every entry is invalid after the edge.
- **Priority.** Reset > flush > issue/enqueue. Issue and enqueue never target the same slot, because enqueue allocates only from registered-free slots.

## Timing
- Reset (async assert): all entries invalid, all ready bits cleared, `uop_out` all-zero, `ready_out`=1.
- Enqueue at edge t: the entry is eligible for `uop_out` in cycle t+1 at the earliest.
- `uop_out` is combinational from registered entry state plus `ex_busy`; minimum enqueue-to-issue latency is 1 cycle.
- Wakeup in cycle t: the waiting entry can issue in cycle t+1.
- Full queue: `ready_out`=0 until registered free count ≥ `DISPATCH_WIDTH`; no partial accept.
- Reset deassert mid-operation: the queue is empty and resumes accepting the following cycle.

## Structure
- `micro_op_t`, its `prs*` fields, and `IQ_INT` live in `common/micro_op.svh`. Add `prs1_ready`/`prs2_ready` there if absent.
- Sub-module `iq_picker`: parameterised lowest-index N-of-M picker producing one-hot selections plus valid bits. It is instantiated twice: free-slot allocation (N=`DISPATCH_WIDTH`) and issue select (N=`ISSUE_WIDTH`, with port masking).

## Test plan
- **Reset:** assert `reset_n`=0 mid-stream → `uop_out` all-zero and `ready_out`=1 immediately; queue empty after release.
- **Ready-to-issue:** 4 uops with all sources ready enqueued at edge 0 → slots 0,1 on ports 0,1 in cycle 1; slots 2,3 in cycle 2.
- **Wakeup:** uop with `prs1`=7 not ready enqueued → no issue; `wb_prd[2]`=7 valid in cycle 3 → issues in cycle 4. Same-cycle enqueue with `wb_prd`=7 → issues in the next cycle.
- **Full queue:** 16 not-ready entries → `ready_out`=0 and a new group is not written. A wakeup releases 4 entries → after they issue, `ready_out`=1.
- **Port busy:** `ex_busy`=2'b01 with 2 ready entries → `uop_out[0]` zero, `uop_out[1]` = slot 0; slot 1 issues the next cycle.
- **Flush:** `flush` with 10 valid entries and a valid `uop_in` → `uop_out` zero that cycle; 0 entries afterward; the group is not enqueued.

Source files
------------

// File: rtl/int_issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// int_issue_queue_pkg
//   Shared types and constants for the integer issue queue:
//     - DISPATCH_WIDTH : uops per dispatch group
//     - PRF_IDX_W      : physical register tag width
//     - ROB_IDX_W      : reorder-buffer index width
//     - iq_type_e      : destination issue-queue class of a uop
//     - micro_op_t     : micro-op payload carried from dispatch to execute
// -----------------------------------------------------------------------------
package int_issue_queue_pkg;

    localparam int DISPATCH_WIDTH = 4;
    localparam int PRF_IDX_W      = 6;
    localparam int ROB_IDX_W      = 6;

    typedef enum logic [1:0] {
        IQ_INT = 2'd0,
        IQ_MEM = 2'd1,
        IQ_FP  = 2'd2
    } iq_type_e;

    typedef struct packed {
        logic                 valid;
        iq_type_e             iq_type;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PRF_IDX_W-1:0] prd;
        logic [PRF_IDX_W-1:0] prs1;
        logic [PRF_IDX_W-1:0] prs2;
        logic                 prs1_ready;
        logic                 prs2_ready;
    } micro_op_t;

endpackage

// File: rtl/int_issue_queue_iq_picker.sv
// -----------------------------------------------------------------------------
// iq_picker
//   Lowest-index N-of-M picker. Grant port p receives the lowest-index request
//   not already claimed by ports below p. A disabled port grants nothing and
//   leaves its candidate available to the ports above it.
//   Ports:
//     req         in  [M]     request vector
//     port_en     in  [N]     per-grant-port enable
//     grant_oh    out [N][M]  one-hot selection per grant port (zero if none)
//     grant_valid out [N]     grant port p selected an entry
// -----------------------------------------------------------------------------
module iq_picker #(
    parameter int M = 16,
    parameter int N = 4
) (
    input  logic [M-1:0]        req,
    input  logic [N-1:0]        port_en,
    output logic [N-1:0][M-1:0] grant_oh,
    output logic [N-1:0]        grant_valid
);

    // avail[p] holds the requests still unclaimed when port p picks.
    logic [N:0][M-1:0] avail;

    assign avail[0] = req;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_port
            logic [M-1:0] lowest;
            // x & -x isolates the lowest set bit.
            assign lowest          = avail[gi] & (~avail[gi] + M'(1));
            assign grant_oh[gi]    = port_en[gi] ? lowest : '0;
            assign grant_valid[gi] = |grant_oh[gi];
            assign avail[gi+1]     = avail[gi] & ~grant_oh[gi];
        end
    endgenerate

endmodule

// File: rtl/int_issue_queue.sv
// -----------------------------------------------------------------------------
// int_issue_queue
//   Integer issue queue fed by the compacted dispatch bundle. Buffers up to
//   IQ_SIZE uops, wakes source operands from writeback tags and issues up to
//   ISSUE_WIDTH ready uops per cycle, lowest slot first. A dispatch group is
//   accepted whole or not at all.
//   Ports:
//     clock      in   clock, rising edge
//     reset_n    in   asynchronous active-low reset
//     flush      in   synchronous clear of all entries
//     uop_in     in   [DISPATCH_WIDTH] micro_op_t, compacted (valid slots low)
//     ready_out  out  a full dispatch group can be accepted this cycle
//     wb_valid   in   [WB_WIDTH] wakeup broadcast valid
//     wb_prd     in   [WB_WIDTH] destination tags being written back
//     ex_busy    in   [ISSUE_WIDTH] execution port cannot accept this cycle
//     uop_out    out  [ISSUE_WIDTH] micro_op_t issued uops (all-zero if idle)
// -----------------------------------------------------------------------------
module int_issue_queue
    import int_issue_queue_pkg::*;
#(
    parameter int IQ_SIZE     = 16,
    parameter int ISSUE_WIDTH = 2,
    parameter int WB_WIDTH    = 4
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  flush,
    input  micro_op_t [DISPATCH_WIDTH-1:0]        uop_in,
    output logic                                  ready_out,
    input  logic [WB_WIDTH-1:0]                   wb_valid,
    input  logic [WB_WIDTH-1:0][PRF_IDX_W-1:0]    wb_prd,
    input  logic [ISSUE_WIDTH-1:0]                ex_busy,
    output micro_op_t [ISSUE_WIDTH-1:0]           uop_out
);

    localparam int CNT_W = $clog2(IQ_SIZE + 1);

    // Entry state
    logic [IQ_SIZE-1:0] valid_reg, valid_next;
    logic [IQ_SIZE-1:0] rs1_rdy_reg, rs1_rdy_next;
    logic [IQ_SIZE-1:0] rs2_rdy_reg, rs2_rdy_next;
    micro_op_t          uop_reg  [IQ_SIZE];
    micro_op_t          uop_next [IQ_SIZE];

    logic [CNT_W-1:0]   free_cnt;
    logic               enq_go;
    logic [IQ_SIZE-1:0] eligible;
    logic [IQ_SIZE-1:0] issue_clr;
    logic [IQ_SIZE-1:0] enq_hit;
    micro_op_t          enq_uop [IQ_SIZE];
    logic [IQ_SIZE-1:0] wake1, wake2;
    logic [IQ_SIZE-1:0] enq_wake1, enq_wake2;

    logic [DISPATCH_WIDTH-1:0][IQ_SIZE-1:0] alloc_oh;
    logic [DISPATCH_WIDTH-1:0]              alloc_vld;
    logic [ISSUE_WIDTH-1:0][IQ_SIZE-1:0]    issue_oh;
    logic [ISSUE_WIDTH-1:0]                 issue_vld;
    logic [ISSUE_WIDTH-1:0]                 issue_en;

    // A broadcast on tag 0 never wakes anything: x0 sources are marked ready
    // at rename, and tag 0 writebacks carry no information.
    function automatic logic tag_woken(
        input logic [PRF_IDX_W-1:0]               tag,
        input logic [WB_WIDTH-1:0]                v,
        input logic [WB_WIDTH-1:0][PRF_IDX_W-1:0] prd
    );
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WB_WIDTH; w++) begin
            if (v[w] && (prd[w] != '0) && (prd[w] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Free count comes only from registered valid bits; entries issuing this
    // cycle still count as occupied, keeping ex_busy off the ready_out path.
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            free_cnt = free_cnt + CNT_W'(!valid_reg[i]);
        end
    end

    assign ready_out = (free_cnt >= CNT_W'(DISPATCH_WIDTH));
    assign enq_go    = ready_out && !flush;

    // Flush suppresses every issue port in the flush cycle.
    assign issue_en  = flush ? '0 : ~ex_busy;

    iq_picker #(
        .M (IQ_SIZE),
        .N (DISPATCH_WIDTH)
    ) u_alloc_picker (
        .req         (~valid_reg),
        .port_en     ({DISPATCH_WIDTH{1'b1}}),
        .grant_oh    (alloc_oh),
        .grant_valid (alloc_vld)
    );

    iq_picker #(
        .M (IQ_SIZE),
        .N (ISSUE_WIDTH)
    ) u_issue_picker (
        .req         (eligible),
        .port_en     (issue_en),
        .grant_oh    (issue_oh),
        .grant_valid (issue_vld)
    );

    genvar gi;
    generate
        for (gi = 0; gi < IQ_SIZE; gi++) begin : g_slot
            assign eligible[gi]  = valid_reg[gi] & rs1_rdy_reg[gi] & rs2_rdy_reg[gi];
            assign wake1[gi]     = valid_reg[gi] & tag_woken(uop_reg[gi].prs1, wb_valid, wb_prd);
            assign wake2[gi]     = valid_reg[gi] & tag_woken(uop_reg[gi].prs2, wb_valid, wb_prd);
            assign enq_wake1[gi] = tag_woken(enq_uop[gi].prs1, wb_valid, wb_prd);
            assign enq_wake2[gi] = tag_woken(enq_uop[gi].prs2, wb_valid, wb_prd);
        end
    endgenerate

    // Route dispatch slot k to the k-th lowest free entry. Because ready_out
    // guarantees at least DISPATCH_WIDTH free entries, every valid slot of
    // the group finds a home.
    always_comb begin
        enq_hit = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            enq_uop[i] = '0;
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                if (enq_go && uop_in[k].valid && alloc_vld[k] && alloc_oh[k][i]) begin
                    enq_hit[i] = 1'b1;
                    enq_uop[i] = uop_in[k];
                end
            end
        end
    end

    // Issue ports: one-hot mux of the selected entry, zero when idle.
    always_comb begin
        issue_clr = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            uop_out[p] = '0;
            if (issue_vld[p]) begin
                for (int i = 0; i < IQ_SIZE; i++) begin
                    if (issue_oh[p][i]) begin
                        uop_out[p] = uop_reg[i];
                    end
                end
            end
            issue_clr = issue_clr | issue_oh[p];
        end
    end

    // Entry next state. Issue and enqueue never hit the same slot since
    // allocation only uses registered-free entries.
    always_comb begin
        for (int i = 0; i < IQ_SIZE; i++) begin
            valid_next[i]   = valid_reg[i];
            rs1_rdy_next[i] = rs1_rdy_reg[i] | wake1[i];
            rs2_rdy_next[i] = rs2_rdy_reg[i] | wake2[i];
            uop_next[i]     = uop_reg[i];
            if (flush || issue_clr[i]) begin
                valid_next[i]   = 1'b0;
                rs1_rdy_next[i] = 1'b0;
                rs2_rdy_next[i] = 1'b0;
            end else if (enq_hit[i]) begin
                valid_next[i]   = 1'b1;
                uop_next[i]     = enq_uop[i];
                rs1_rdy_next[i] = enq_uop[i].prs1_ready | enq_wake1[i];
                rs2_rdy_next[i] = enq_uop[i].prs2_ready | enq_wake2[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_reg   <= '0;
            rs1_rdy_reg <= '0;
            rs2_rdy_reg <= '0;
            for (int i = 0; i < IQ_SIZE; i++) begin
                uop_reg[i] <= '0;
            end
        end else begin
            valid_reg   <= valid_next;
            rs1_rdy_reg <= rs1_rdy_next;
            rs2_rdy_reg <= rs2_rdy_next;
            for (int i = 0; i < IQ_SIZE; i++) begin
                uop_reg[i] <= uop_next[i];
            end
        end
    end

endmodule

// File: tb/tb_int_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_int_issue_queue
//   Self-checking bench for int_issue_queue: a directed vector table, short
//   hand-written corner-case sequences, and randomized traffic compared
//   against a slot-level reference model of the queue.
// -----------------------------------------------------------------------------
module tb_int_issue_queue;
    import int_issue_queue_pkg::*;

    localparam int IQ = 16;
    localparam int IW = 2;
    localparam int WB = 4;
    localparam int DW = DISPATCH_WIDTH;

    logic                           clock = 1'b0;
    logic                           reset_n = 1'b1;
    logic                           flush;
    micro_op_t [DW-1:0]             uop_in;
    logic                           ready_out;
    logic [WB-1:0]                  wb_valid;
    logic [WB-1:0][PRF_IDX_W-1:0]   wb_prd;
    logic [IW-1:0]                  ex_busy;
    micro_op_t [IW-1:0]             uop_out;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: occupancy, payload and operand readiness per slot.
    bit        m_valid [IQ];
    micro_op_t m_uop   [IQ];
    bit        m_r1    [IQ];
    bit        m_r2    [IQ];
    bit        m_last_ready;
    bit        m_last_flush;

    typedef struct {
        int            n_uops;
        int            prd_base;
        logic [IW-1:0] busy;
        bit            fl;
        bit            exp_ready;
        int            exp_p0;   // expected issued prd, 0 = port idle
        int            exp_p1;
    } vec_t;

    vec_t tbl [7];

    int_issue_queue #(
        .IQ_SIZE     (IQ),
        .ISSUE_WIDTH (IW),
        .WB_WIDTH    (WB)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .uop_in    (uop_in),
        .ready_out (ready_out),
        .wb_valid  (wb_valid),
        .wb_prd    (wb_prd),
        .ex_busy   (ex_busy),
        .uop_out   (uop_out)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic micro_op_t mk_uop(int prd, int prs1, int prs2, bit r1, bit r2);
        micro_op_t u;
        u            = '0;
        u.valid      = 1'b1;
        u.iq_type    = IQ_INT;
        u.rob_idx    = ROB_IDX_W'(prd);
        u.prd        = PRF_IDX_W'(prd);
        u.prs1       = PRF_IDX_W'(prs1);
        u.prs2       = PRF_IDX_W'(prs2);
        u.prs1_ready = r1;
        u.prs2_ready = r2;
        return u;
    endfunction

    function automatic bit woken(logic [PRF_IDX_W-1:0] tag);
        for (int w = 0; w < WB; w++) begin
            if (wb_valid[w] && wb_prd[w] != 0 && wb_prd[w] == tag) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < IQ; i++) begin
            m_valid[i] = 1'b0;
            m_uop[i]   = '0;
            m_r1[i]    = 1'b0;
            m_r2[i]    = 1'b0;
        end
        m_last_ready = 1'b1;
        m_last_flush = 1'b0;
    endfunction

    task automatic chk_bit(string name, logic got, logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0b required=%0b", name, cyc, got, exp);
        end
    endtask

    task automatic chk_uop(string name, micro_op_t got, micro_op_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, exp);
        end
    endtask

    // Checks the issued prd on a port; exp_prd 0 means the port must be idle.
    task automatic chk_prd(string name, micro_op_t got, int exp_prd);
        bit ok;
        vectors++;
        if (exp_prd == 0) ok = (got === '0);
        else              ok = (got.valid === 1'b1) && (got.prd === PRF_IDX_W'(exp_prd));
        if (!ok) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=valid%0b/prd%0d required=prd%0d",
                     name, cyc, got.valid, got.prd, exp_prd);
        end
    endtask

    task automatic clear_inputs();
        flush    = 1'b0;
        uop_in   = '0;
        wb_valid = '0;
        wb_prd   = '0;
        ex_busy  = '0;
    endtask

    task automatic set_group(int n, int base, int prs1, bit r1);
        for (int k = 0; k < DW; k++) begin
            uop_in[k] = (k < n) ? mk_uop(base + k, prs1, 0, r1, 1'b1) : '0;
        end
    endtask

    // Called after inputs are driven on the falling edge: compares the DUT
    // against the model, then advances the model across the next rising edge.
    task automatic apply();
        int        free_slots[$];
        int        elig[$];
        int        issued[$];
        micro_op_t exp_out;
        bit        exp_ready;
        int        n;
        #1;
        for (int i = 0; i < IQ; i++) if (!m_valid[i]) free_slots.push_back(i);
        exp_ready = (free_slots.size() >= DW);
        chk_bit("ready_out", ready_out, exp_ready);
        for (int i = 0; i < IQ; i++) if (m_valid[i] && m_r1[i] && m_r2[i]) elig.push_back(i);
        for (int p = 0; p < IW; p++) begin
            exp_out = '0;
            if (!flush && !ex_busy[p] && elig.size() > 0) begin
                exp_out = m_uop[elig[0]];
                issued.push_back(elig[0]);
                void'(elig.pop_front());
            end
            chk_uop($sformatf("uop_out%0d", p), uop_out[p], exp_out);
        end
        $display("cyc %0d: ready=%0b busy=%b flush=%0b out0=%0d/%0d out1=%0d/%0d",
                 cyc, ready_out, ex_busy, flush, uop_out[0].valid, uop_out[0].prd,
                 uop_out[1].valid, uop_out[1].prd);
        if (flush) begin
            for (int i = 0; i < IQ; i++) begin
                m_valid[i] = 1'b0;
                m_r1[i]    = 1'b0;
                m_r2[i]    = 1'b0;
            end
        end else begin
            foreach (issued[j]) m_valid[issued[j]] = 1'b0;
            for (int i = 0; i < IQ; i++) begin
                if (m_valid[i]) begin
                    m_r1[i] = m_r1[i] | woken(m_uop[i].prs1);
                    m_r2[i] = m_r2[i] | woken(m_uop[i].prs2);
                end
            end
            if (exp_ready) begin
                n = 0;
                for (int k = 0; k < DW; k++) begin
                    if (uop_in[k].valid) begin
                        m_valid[free_slots[n]] = 1'b1;
                        m_uop[free_slots[n]]   = uop_in[k];
                        m_r1[free_slots[n]]    = uop_in[k].prs1_ready | woken(uop_in[k].prs1);
                        m_r2[free_slots[n]]    = uop_in[k].prs2_ready | woken(uop_in[k].prs2);
                        n++;
                    end
                end
            end
        end
        m_last_ready = exp_ready;
        m_last_flush = flush;
        cyc++;
    endtask

    initial begin
        clear_inputs();
        model_reset();

        // Reset state
        #1 reset_n = 1'b0;
        #1;
        chk_bit("reset_ready", ready_out, 1'b1);
        chk_uop("reset_out0", uop_out[0], '0);
        chk_uop("reset_out1", uop_out[1], '0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Directed table: ready-to-issue ordering and port masking
        tbl[0] = '{4, 1, 2'b00, 1'b0, 1'b1, 0, 0};
        tbl[1] = '{0, 0, 2'b00, 1'b0, 1'b1, 1, 2};
        tbl[2] = '{0, 0, 2'b00, 1'b0, 1'b1, 3, 4};
        tbl[3] = '{2, 5, 2'b00, 1'b0, 1'b1, 0, 0};
        tbl[4] = '{0, 0, 2'b01, 1'b0, 1'b1, 0, 5};
        tbl[5] = '{0, 0, 2'b00, 1'b0, 1'b1, 6, 0};
        tbl[6] = '{0, 0, 2'b11, 1'b0, 1'b1, 0, 0};
        for (int r = 0; r < 7; r++) begin
            @(negedge clock);
            clear_inputs();
            set_group(tbl[r].n_uops, tbl[r].prd_base, 0, 1'b1);
            ex_busy = tbl[r].busy;
            flush   = tbl[r].fl;
            apply();
            chk_bit("tbl_ready", ready_out, tbl[r].exp_ready);
            chk_prd("tbl_p0", uop_out[0], tbl[r].exp_p0);
            chk_prd("tbl_p1", uop_out[1], tbl[r].exp_p1);
        end

        // Wakeup: waits for tag 7, issues the cycle after the broadcast
        @(negedge clock); clear_inputs(); set_group(1, 10, 7, 1'b0); apply();
        @(negedge clock); clear_inputs(); apply(); chk_prd("wk_wait1", uop_out[0], 0);
        @(negedge clock); clear_inputs(); apply(); chk_prd("wk_wait2", uop_out[0], 0);
        @(negedge clock); clear_inputs(); wb_valid[2] = 1'b1; wb_prd[2] = 6'd7;
        apply(); chk_prd("wk_bcast", uop_out[0], 0);
        @(negedge clock); clear_inputs(); apply(); chk_prd("wk_issue", uop_out[0], 10);
        // Tag 0 broadcast must not wake a waiting prs1=0
        @(negedge clock); clear_inputs(); set_group(1, 12, 0, 1'b0); apply();
        @(negedge clock); clear_inputs(); wb_valid = '1; apply();
        @(negedge clock); clear_inputs(); apply(); chk_prd("tag0_nowake", uop_out[0], 0);
        @(negedge clock); clear_inputs(); flush = 1'b1; apply();
        // Same-cycle enqueue and wakeup
        @(negedge clock); clear_inputs(); set_group(1, 11, 7, 1'b0);
        wb_valid[0] = 1'b1; wb_prd[0] = 6'd7; apply();
        @(negedge clock); clear_inputs(); apply(); chk_prd("wk_same", uop_out[0], 11);

        // Full queue, whole-group backpressure, then flush
        for (int g = 0; g < 4; g++) begin
            @(negedge clock); clear_inputs();
            set_group(4, 20 + 4 * g, (g == 0) ? 40 : 41, 1'b0); apply();
        end
        @(negedge clock); clear_inputs(); set_group(4, 44, 0, 1'b1); apply();
        chk_bit("full_ready", ready_out, 1'b0);
        @(negedge clock); wb_valid[1] = 1'b1; wb_prd[1] = 6'd40; apply();
        chk_bit("full_ready_wk", ready_out, 1'b0);
        @(negedge clock); wb_valid = '0; apply();
        chk_prd("full_rel_p0", uop_out[0], 20);
        chk_prd("full_rel_p1", uop_out[1], 21);
        @(negedge clock); apply(); chk_bit("full_two_free", ready_out, 1'b0);
        @(negedge clock); apply(); chk_bit("full_four_free", ready_out, 1'b1);
        @(negedge clock); clear_inputs(); set_group(4, 50, 0, 1'b1); flush = 1'b1; apply();
        chk_prd("flush_p0", uop_out[0], 0);
        chk_prd("flush_p1", uop_out[1], 0);
        @(negedge clock); clear_inputs(); wb_valid = '1;
        wb_prd[0] = 6'd41; wb_prd[1] = 6'd40; wb_prd[2] = 6'd44; wb_prd[3] = 6'd50;
        apply(); chk_bit("flush_empty", ready_out, 1'b1);
        @(negedge clock); clear_inputs(); apply();
        chk_prd("flush_none_p0", uop_out[0], 0);

        // Randomized traffic against the model
        for (int c = 0; c < 1000; c++) begin
            @(negedge clock);
            if (m_last_ready || m_last_flush) begin
                int n;
                n = $urandom_range(0, DW);
                for (int k = 0; k < DW; k++) begin
                    if (k < n) begin
                        int p1, p2;
                        p1 = $urandom_range(0, 15);
                        p2 = $urandom_range(0, 15);
                        uop_in[k] = mk_uop($urandom_range(1, 63), p1, p2,
                                           (p1 == 0) || ($urandom_range(0, 3) == 0),
                                           (p2 == 0) || ($urandom_range(0, 3) == 0));
                    end else begin
                        uop_in[k] = '0;
                    end
                end
            end
            for (int w = 0; w < WB; w++) begin
                wb_valid[w] = 1'($urandom_range(0, 1));
                wb_prd[w]   = PRF_IDX_W'($urandom_range(0, 15));
            end
            ex_busy = IW'($urandom_range(0, 3));
            flush   = ($urandom_range(0, 63) == 0);
            apply();
        end

        // Asynchronous reset mid-stream
        @(negedge clock);
        clear_inputs();
        #2 reset_n = 1'b0;
        #1;
        chk_bit("mid_reset_ready", ready_out, 1'b1);
        chk_uop("mid_reset_out0", uop_out[0], '0);
        chk_uop("mid_reset_out1", uop_out[1], '0);
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        set_group(4, 60, 0, 1'b1);
        apply();
        @(negedge clock); clear_inputs(); apply();
        chk_prd("post_reset_p0", uop_out[0], 60);
        chk_prd("post_reset_p1", uop_out[1], 61);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
